// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the radix-4 Booth
//               sum-and-shift multiplier (FSM state encoding, Booth
//               partial-product select encoding, radix-4 step width).
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Bits consumed from the multiplier (and shifted out of the
    // accumulator) per RUN step.
    localparam int c_step_w = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Partial-product select: 0, +M, +2M, -M, -2M.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        MM   = 3'd3,
        M2M  = 3'd4
    } booth_sel_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/booth_r4_encoder.sv
`default_nettype none
// ============================================================================
// Module      : booth_r4_encoder
// Description : Combinational radix-4 Booth recoder. Maps the overlapping
//               multiplier triplet {q1, q0, prev} to a partial-product
//               select.
// Ports       : booth_bits [2:0] in  - {q1, q0, prev}
//               sel        [2:0] out - booth_sel_t select
// Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_encoder
    import mult_pkg::*;
(
    input  logic [2:0] booth_bits,
    output booth_sel_t sel
);

    always_comb begin
        sel = ZERO;
        case (booth_bits)
            3'b001, 3'b010: sel = PM;
            3'b011:         sel = P2M;
            3'b100:         sel = M2M;
            3'b101, 3'b110: sel = MM;
            default:        sel = ZERO;  // 000 and 111
        endcase
    end

endmodule : booth_r4_encoder
`default_nettype wire

// File: rtl/booth_r4_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_r4_acc_ctrl
// Description : Radix-4 Booth control and high-accumulator stage of the
//               sum-and-shift multiplier. Consumes two multiplier bits per
//               step from the external low-half shift register, adds
//               0/+-M/+-2M into a (SIZE+2)-bit accumulator, returns the two
//               bits shifted out of the accumulator to that register, and
//               sequences the register load/shift with a start/done
//               handshake. Full product = {hi_product, low register}.
// Parameters  : SIZE - operand width, even and >= 4 (signed operands)
// Ports       : CLOCK         in   rising-edge clock
//               RESET         in   asynchronous active-high reset
//               start         in   request, sampled only in IDLE
//               multiplicand  in   M, captured when start is accepted
//               lo_serial     in   {q1,q0} from the low register
//               lo_mode       out  1 = parallel load, 0 = shift
//               lo_enable     out  low-register enable
//               hi_serial_out out  accumulator bits into low register
//               hi_product    out  high half of the product
//               busy          out  operation in progress
//               done          out  one-cycle completion pulse
// Option      : MULT_STEP_MON_EN adds step_cnt and booth_sel monitor
//               outputs (both zero outside RUN).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_acc_ctrl
    import mult_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic                          start,
    input  logic [SIZE-1:0]               multiplicand,
    input  logic [1:0]                    lo_serial,
    output logic                          lo_mode,
    output logic                          lo_enable,
    output logic [1:0]                    hi_serial_out,
    output logic [SIZE-1:0]               hi_product,
    output logic                          busy,
    output logic                          done
`ifdef MULT_STEP_MON_EN
    ,
    output logic [$clog2(SIZE/2+1)-1:0]   step_cnt,
    output logic [2:0]                    booth_sel
`endif
);

    // Two guard bits so that +-2M of the most negative M cannot overflow.
    localparam int c_acc_w = SIZE + c_step_w;
    localparam int c_cnt_w = $clog2(SIZE/2 + 1);

    state_t               r_state;
    logic [SIZE-1:0]      r_m;
    logic [c_acc_w-1:0]   r_acc;
    logic                 r_prev;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_lo_mode;
    logic                 r_lo_enable;
    logic                 r_busy;
    logic                 r_done;

    logic [2:0]           w_booth_bits;
    booth_sel_t           w_sel;
    logic [c_acc_w-1:0]   w_m_ext;
    logic [c_acc_w-1:0]   w_pp;
    logic [c_acc_w-1:0]   w_sum;
    logic [c_acc_w-1:0]   w_acc_next;

    // ------------------------------------------------------------------
    // Booth recode and partial-product datapath
    // ------------------------------------------------------------------
    assign w_booth_bits = {lo_serial, r_prev};

    booth_r4_encoder u_encoder (
        .booth_bits (w_booth_bits),
        .sel        (w_sel)
    );

    assign w_m_ext = {{c_step_w{r_m[SIZE-1]}}, r_m};

    always_comb begin
        w_pp = '0;
        case (w_sel)
            PM:      w_pp = w_m_ext;
            P2M:     w_pp = w_m_ext << 1;
            MM:      w_pp = -w_m_ext;
            M2M:     w_pp = -(w_m_ext << 1);
            default: w_pp = '0;
        endcase
    end

    // Addition wraps modulo 2^(SIZE+2); the two low bits leave toward the
    // low register and the rest is shifted right arithmetically.
    assign w_sum      = r_acc + w_pp;
    assign w_acc_next = {{c_step_w{w_sum[c_acc_w-1]}}, w_sum[c_acc_w-1:c_step_w]};

    // The low register samples this on the same edge that updates r_acc.
    assign hi_serial_out = (r_state == RUN) ? w_sum[1:0] : 2'b00;

    // ------------------------------------------------------------------
    // Control FSM with registered handshake / register-control outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_m         <= '0;
            r_acc       <= '0;
            r_prev      <= 1'b0;
            r_count     <= '0;
            r_lo_mode   <= 1'b0;
            r_lo_enable <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m         <= multiplicand;
                        r_acc       <= '0;
                        r_prev      <= 1'b0;
                        r_count     <= c_cnt_w'(SIZE/2);
                        r_lo_mode   <= 1'b1;
                        r_lo_enable <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    r_lo_mode   <= 1'b0;
                    r_lo_enable <= 1'b1;
                    r_state     <= RUN;
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_prev  <= lo_serial[1];
                    r_count <= r_count - c_cnt_w'(1);
                    // Last step: product lands on this edge, so done and
                    // the busy drop are presented in the following cycle.
                    if (r_count == c_cnt_w'(1)) begin
                        r_lo_enable <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= FINISH;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign lo_mode    = r_lo_mode;
    assign lo_enable  = r_lo_enable;
    assign busy       = r_busy;
    assign done       = r_done;
    assign hi_product = r_acc[SIZE-1:0];

`ifdef MULT_STEP_MON_EN
    assign step_cnt  = (r_state == RUN) ? r_count : '0;
    assign booth_sel = (r_state == RUN) ? w_sel : ZERO;
`endif

endmodule : booth_r4_acc_ctrl
`default_nettype wire

// File: tb/tb_booth_r4_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_r4_acc_ctrl
// Description : Self-checking bench for booth_r4_acc_ctrl (SIZE = 8) with a
//               behavioural model of the low-half 2-bit shift register and
//               a queue of expected products.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_r4_acc_ctrl;

    localparam int SIZE = 8;

    logic             CLOCK = 1'b0;
    logic             RESET;
    logic             start;
    logic [SIZE-1:0]  multiplicand;
    logic [1:0]       lo_serial;
    logic             lo_mode;
    logic             lo_enable;
    logic [1:0]       hi_serial_out;
    logic [SIZE-1:0]  hi_product;
    logic             busy;
    logic             done;
`ifdef MULT_STEP_MON_EN
    logic [$clog2(SIZE/2+1)-1:0] step_cnt;
    logic [2:0]                  booth_sel;
`endif

    logic [SIZE-1:0]  lo_par;
    logic [SIZE-1:0]  lo_reg = '0;
    logic [15:0]      exp_q[$];
    int               n_assert = 0;
    int               n_fail   = 0;

    booth_r4_acc_ctrl #(.SIZE(SIZE)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .start         (start),
        .multiplicand  (multiplicand),
        .lo_serial     (lo_serial),
        .lo_mode       (lo_mode),
        .lo_enable     (lo_enable),
        .hi_serial_out (hi_serial_out),
        .hi_product    (hi_product),
        .busy          (busy),
        .done          (done)
`ifdef MULT_STEP_MON_EN
        ,
        .step_cnt      (step_cnt),
        .booth_sel     (booth_sel)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    // Low-half register: parallel load of the multiplier, or shift right by
    // two with the accumulator bits entering at the top.
    always @(posedge CLOCK) begin
        if (lo_enable)
            lo_reg <= lo_mode ? lo_par : {hi_serial_out, lo_reg[SIZE-1:2]};
    end
    assign lo_serial = lo_reg[1:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; start is raised immediately so back-to-back calls
    // exercise the earliest legal restart. poke pulses start in RUN and in
    // the FINISH cycle.
    task automatic run_mult(input logic [7:0] m, input logic [7:0] q,
                            input logic [15:0] expected, input bit poke);
        int          cyc;
        bit          seen;
        logic [15:0] want;
        multiplicand = m;
        lo_par       = q;
        start        = 1'b1;
        exp_q.push_back(expected);
        @(negedge CLOCK);
        start = 1'b0;
        cyc   = 1;
        // LOAD cycle
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("load_ctl", {30'd0, lo_mode, lo_enable}, 32'd3);
        check("hi_clr_on_accept", {24'd0, hi_product}, 32'd0);
        check("serial_out_load", {30'd0, hi_serial_out}, 32'd0);
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge CLOCK);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else begin
                check("run_ctl", {29'd0, busy, lo_mode, lo_enable}, 32'd5);
`ifdef MULT_STEP_MON_EN
                check("step_cnt", {29'd0, step_cnt}, 32'(6 - cyc));
`endif
                start = (poke && cyc == 3);
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("done_latency", cyc, 32'd6);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("product", {16'd0, hi_product, lo_reg}, {16'd0, want});
        check("busy_fall", {31'd0, busy}, 32'd0);
        start = poke;
        @(negedge CLOCK);
        start = 1'b0;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after_done", {29'd0, busy, lo_mode, lo_enable}, 32'd0);
        check("hi_hold", {24'd0, hi_product}, {24'd0, expected[15:8]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        RESET        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        lo_par       = '0;
        repeat (2) @(negedge CLOCK);
        check("reset_outputs",
              {18'd0, lo_mode, lo_enable, hi_serial_out, hi_product, busy, done}, 32'd0);
        RESET = 1'b0;
        @(negedge CLOCK);

        run_mult(8'd3,   8'd5,   16'h000F, 1'b0);
        run_mult(8'hF9,  8'd6,   16'hFFD6, 1'b0);   // -7 x 6
        run_mult(8'h80,  8'h80,  16'h4000, 1'b0);   // -128 x -128
        run_mult(8'h7F,  8'h80,  16'hC080, 1'b0);   // 127 x -128
        run_mult(8'd3,   8'd5,   16'h000F, 1'b1);   // stray starts ignored

        // Reset in the second RUN cycle of a 3 x 5 (hi_serial_out is 2'b11 there)
        multiplicand = 8'd3;
        lo_par       = 8'd5;
        start        = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        check("run2_serial_before_reset", {30'd0, hi_serial_out}, 32'd3);
        #2 RESET = 1'b1;
        #1;
        check("reset_midrun",
              {18'd0, lo_mode, lo_enable, hi_serial_out, hi_product, busy, done}, 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        check("idle_after_reset", {30'd0, busy, done}, 32'd0);
        run_mult(8'd3,   8'd5,   16'h000F, 1'b0);

        // Back-to-back
        run_mult(8'd5,   8'hFF,  16'hFFFB, 1'b0);   // 5 x -1
        run_mult(8'hFF,  8'hFF,  16'h0001, 1'b0);   // -1 x -1

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_booth_r4_acc_ctrl
`default_nettype wire
